// File: rtl/corelet_pkg.sv
// Shared definitions for the corelet sequencer: FSM state encoding and the
// bit positions of the fields the sequencer drives in the 35-bit inst word.
package corelet_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LD_W  = 3'd1,
      S_KLOAD = 3'd2,
      S_LD_A  = 3'd3,
      S_EXEC  = 3'd4,
      S_DRAIN = 3'd5,
      S_FIN   = 3'd6
   } state_t;

   localparam int INST_W     = 35;
   localparam int INST_KLOAD = 0;
   localparam int INST_EXEC  = 1;
   localparam int INST_L0WR  = 2;
   localparam int INST_L0RD  = 3;
   localparam int INST_OFRD  = 6;
   localparam int INST_ACC   = 33;
   localparam int INST_MODE  = 34;

endpackage

// File: rtl/corelet_seq_sram_rd.sv
// seq_sram_rd: xmem read sequencer shared by the weight and activation load
// phases. Issues `count` reads at base+0..count-1, holding off (cen=1, address
// frozen) while stall is high, and produces the L0 write strobe one cycle
// after each read so L0 captures the SRAM output.
//   clk, reset  clock, synchronous active-low reset
//   en          phase active; counter clears while low
//   stall       L0 full, no read this cycle
//   base/count  first address and number of reads for the phase
//   cen/addr    registered xmem chip enable (active-low) and address
//   wr          registered L0 write strobe
//   last        the final L0 write is on the bus this cycle
module seq_sram_rd #(
   parameter int addr_bw = 11,
   parameter int cnt_bw  = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               stall,
   input  logic [addr_bw-1:0] base,
   input  logic [cnt_bw-1:0]  count,
   output logic               cen,
   output logic [addr_bw-1:0] addr,
   output logic               wr,
   output logic               last
);

   logic [cnt_bw-1:0] cnt;
   logic              issue;

   assign issue = en && (cnt != count) && !stall;

   // All reads issued, the final read has returned and its strobe is now up.
   assign last = en && (cnt == count) && cen && wr;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt  <= '0;
         cen  <= 1'b1;
         addr <= '0;
         wr   <= 1'b0;
      end else begin
         wr  <= ~cen;
         cen <= ~issue;
         if (issue) begin
            addr <= base + addr_bw'(cnt);
            cnt  <= cnt + cnt_bw'(1);
         end else if (!en) begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/corelet_seq.sv
// corelet_seq: weight-stationary sequencer for one corelet. For each kernel
// position it loads col weights into L0, shifts them into the MAC array,
// streams n_act activations, then drains the OFIFO into pmem.
//   clk, reset            clock, synchronous active-low reset
//   start, mode, n_kij,   run request and its parameters, latched in IDLE
//   n_act, w_base
//   l0_full, ofifo_valid  corelet status
//   inst                  corelet instruction word
//   xmem_cen/addr         activation/weight SRAM read port
//   pmem_cen/wen/addr     psum SRAM write port
//   busy, done            run status; done pulses once at the end of a run
//
// state   | meaning
// IDLE    | waiting for start
// LD_W    | read col weights for kernel position kij into L0
// KLOAD   | shift weights from L0 into the MAC array (col+row cycles)
// LD_A    | read n_act activation vectors into L0
// EXEC    | stream activations through the array (n_act cycles)
// DRAIN   | pop n_act OFIFO rows and write them to pmem
// FIN     | one-cycle done pulse
module corelet_seq
   import corelet_pkg::*;
#(
   parameter int row     = 8,
   parameter int col     = 8,
   parameter int addr_bw = 11,
   parameter int cnt_bw  = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               mode,
   input  logic [cnt_bw-1:0]  n_kij,
   input  logic [cnt_bw-1:0]  n_act,
   input  logic [addr_bw-1:0] w_base,
   input  logic               l0_full,
   input  logic               ofifo_valid,
   output logic [INST_W-1:0]  inst,
   output logic               xmem_cen,
   output logic [addr_bw-1:0] xmem_addr,
   output logic               pmem_cen,
   output logic               pmem_wen,
   output logic [addr_bw-1:0] pmem_addr,
   output logic               busy,
   output logic               done
);

   state_t state, state_nx;

   logic               mode_l;
   logic [cnt_bw-1:0]  n_kij_l, n_act_l;
   logic [addr_bw-1:0] w_base_l;

   logic [cnt_bw-1:0]  kij, tmr, j;
   logic [cnt_bw:0]    kij_inc;
   logic               drain_rd;

   logic               rd_en, rd_last, l0_wr;
   logic [addr_bw-1:0] rd_base;
   logic [cnt_bw-1:0]  rd_count;

   logic               kload_q, exec_q, l0rd_q, ofrd_q, acc_q, mode_q;
   logic [addr_bw-1:0] pend_addr;

   assign kij_inc  = {1'b0, kij} + (cnt_bw + 1)'(1);
   assign drain_rd = (state == S_DRAIN) && ofifo_valid && (j != n_act_l);

   assign rd_en    = (state == S_LD_W) || (state == S_LD_A);
   assign rd_base  = (state == S_LD_W) ?
                     w_base_l + addr_bw'(kij) * addr_bw'(col) : '0;
   assign rd_count = (state == S_LD_W) ? cnt_bw'(col) : n_act_l;

   seq_sram_rd #(
      .addr_bw (addr_bw),
      .cnt_bw  (cnt_bw)
   ) u_rd (
      .clk   (clk),
      .reset (reset),
      .en    (rd_en),
      .stall (l0_full),
      .base  (rd_base),
      .count (rd_count),
      .cen   (xmem_cen),
      .addr  (xmem_addr),
      .wr    (l0_wr),
      .last  (rd_last)
   );

   always_ff @(posedge clk) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = (n_kij == '0) ? S_FIN : S_LD_W;
         S_LD_W:  if (rd_last) state_nx = S_KLOAD;
         S_KLOAD: if (tmr == '0) state_nx = S_LD_A;
         S_LD_A:  if (rd_last) state_nx = S_EXEC;
         S_EXEC:  if (tmr == '0) state_nx = S_DRAIN;
         S_DRAIN: if (j == n_act_l)
                     state_nx = (kij_inc < {1'b0, n_kij_l}) ? S_LD_W : S_FIN;
         S_FIN:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Run parameters and phase counters; tmr is loaded as each timed phase is
   // entered and counts down to its terminal value of zero.
   always_ff @(posedge clk) begin
      if (!reset) begin
         mode_l   <= 1'b0;
         n_kij_l  <= '0;
         n_act_l  <= '0;
         w_base_l <= '0;
         kij      <= '0;
         tmr      <= '0;
         j        <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               mode_l   <= mode;
               n_kij_l  <= n_kij;
               n_act_l  <= n_act;
               w_base_l <= w_base;
               kij      <= '0;
            end
            S_LD_W:  if (rd_last) tmr <= cnt_bw'(col + row - 1);
            S_LD_A:  if (rd_last) tmr <= n_act_l - cnt_bw'(1);
            S_KLOAD, S_EXEC: if (tmr != '0) tmr <= tmr - cnt_bw'(1);
            S_DRAIN: if (j == n_act_l) kij <= kij + cnt_bw'(1);
            default: ;
         endcase
         if (drain_rd)              j <= j + cnt_bw'(1);
         else if (state != S_DRAIN) j <= '0;
      end
   end

   // Output registers. The pmem write trails its OFIFO pop by one cycle, so
   // the destination address is captured alongside the pop.
   always_ff @(posedge clk) begin
      if (!reset) begin
         kload_q   <= 1'b0;
         exec_q    <= 1'b0;
         l0rd_q    <= 1'b0;
         ofrd_q    <= 1'b0;
         acc_q     <= 1'b0;
         mode_q    <= 1'b0;
         pend_addr <= '0;
         pmem_cen  <= 1'b1;
         pmem_wen  <= 1'b1;
         pmem_addr <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         kload_q  <= (state == S_KLOAD);
         exec_q   <= (state == S_EXEC);
         l0rd_q   <= ((state == S_KLOAD) && (tmr >= cnt_bw'(row))) ||
                     (state == S_EXEC);
         ofrd_q   <= drain_rd;
         acc_q    <= drain_rd && (kij != '0);
         mode_q   <= mode_l && (state != S_IDLE);
         busy     <= (state != S_IDLE);
         done     <= (state == S_FIN);
         pmem_cen <= ~ofrd_q;
         pmem_wen <= ~ofrd_q;
         if (drain_rd)
            pend_addr <= addr_bw'(kij) * addr_bw'(n_act_l) + addr_bw'(j);
         if (ofrd_q)
            pmem_addr <= pend_addr;
      end
   end

   always_comb begin
      inst            = '0;
      inst[INST_KLOAD] = kload_q;
      inst[INST_EXEC]  = exec_q;
      inst[INST_L0WR]  = l0_wr;
      inst[INST_L0RD]  = l0rd_q;
      inst[INST_OFRD]  = ofrd_q;
      inst[INST_ACC]   = acc_q;
      inst[INST_MODE]  = mode_q;
   end

endmodule
